// File: rtl/muxpga_pkg.sv
// Shared constants, state encoding and checksum helper for the mux-grid tile
// configuration loader.
package muxpga_pkg;

  localparam int ROWS        = 5;
  localparam int COLS        = 5;
  localparam int CELL_BITS   = 4;
  localparam int SYNC_STAGES = 2;
  localparam int NCELL       = ROWS * COLS;
  localparam int CFG_W       = NCELL * CELL_BITS;
  localparam int CNT_W       = $clog2(CFG_W + 1);

  localparam logic [CELL_BITS-1:0] HEADER = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    WAIT_END
  } state_e;

  // XOR of every cell nibble in a packed configuration image.
  function automatic logic [CELL_BITS-1:0] nibble_xor(input logic [CFG_W-1:0] v);
    logic [CELL_BITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < NCELL; i++) begin
      acc = acc ^ v[CELL_BITS*i +: CELL_BITS];
    end
    return acc;
  endfunction

endpackage

// File: rtl/muxpga_pin_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module muxpga_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/muxpga_cfg_loader.sv
// Serial bitstream loader: checks header and nibble-XOR checksum, then commits
// a shadow image of all cell configs to the grid in a single cycle.
module muxpga_cfg_loader
  import muxpga_pkg::*;
#(
  parameter int SYNC_DEPTH = SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sdi,
  input  logic             sframe,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             err,
  output logic             busy,
  output logic             sdo
);

  // Arrival order is MSB-first per cell; flipping the low index bits maps the
  // running bit count onto the packed position (CELL_BITS is a power of two).
  localparam logic [CNT_W-1:0] BIT_FLIP  = CNT_W'(CELL_BITS - 1);
  localparam logic [CNT_W-1:0] NIB_LAST  = CNT_W'(CELL_BITS - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(CFG_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic sframe_s, sframe_rise, sframe_fall;
  logic unused_edges;

  muxpga_pin_sync #(.STAGES(SYNC_DEPTH)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  muxpga_pin_sync #(.STAGES(SYNC_DEPTH)) u_sync_sdi (
    .clk(clk), .reset(reset), .d_i(sdi),
    .q_o(sdi_s), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );
  muxpga_pin_sync #(.STAGES(SYNC_DEPTH)) u_sync_sframe (
    .clk(clk), .reset(reset), .d_i(sframe),
    .q_o(sframe_s), .rise_o(sframe_rise), .fall_o(sframe_fall)
  );

  assign unused_edges = ^{sclk_s, sclk_fall, sdi_rise, sdi_fall};

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       rot_q, rot_d;
  logic [CNT_W-1:0]       wr_idx;
  logic [CELL_BITS-1:0]   shift_q, shift_d, shift_nxt;
  logic [CFG_W-1:0]       shadow_q, shadow_d;
  logic [CFG_W-1:0]       cfg_q, cfg_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   sample;

  assign sample = sclk_rise & sframe_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rot_d     = rot_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    valid_d   = valid_q;
    err_d     = err_q;
    shift_nxt = {shift_q[CELL_BITS-2:0], sdi_s};
    wr_idx    = cnt_q ^ BIT_FLIP;

    case (state_q)
      IDLE: begin
        if (sframe_rise) begin
          state_d = HDR;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      HDR, CHK: begin
        if (sframe_fall) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
          rot_d   = '0;
        end else if (sample) begin
          shift_d = shift_nxt;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == NIB_LAST) begin
            cnt_d = '0;
            if (state_q == HDR) begin
              if (shift_nxt == HEADER) begin
                state_d = LOAD;
              end else begin
                state_d = WAIT_END;
                err_d   = 1'b1;
              end
            end else begin
              state_d = WAIT_END;
              rot_d   = '0;
              if (shift_nxt == nibble_xor(shadow_q)) begin
                cfg_d   = shadow_q;
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
      end
      LOAD: begin
        if (sframe_fall) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
          rot_d   = '0;
        end else if (sample) begin
          shadow_d[wr_idx] = sdi_s;
          rot_d = (rot_q == LOAD_LAST) ? '0 : rot_q + CNT_W'(1);
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = CHK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_END: begin
        if (!sframe_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rot_q   <= '0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Assembly registers are fully rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    shift_q  <= shift_d;
  end

  assign cfg_out   = cfg_q;
  assign cfg_valid = valid_q;
  assign err       = err_q;
  assign busy      = (state_q inside {HDR, LOAD, CHK});
  assign sdo       = cfg_q[rot_q ^ BIT_FLIP];

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Bench for muxpga_cfg_loader: drives framed bitstreams on the slow pins and
// compares outputs against a cell-array model of the committed configuration.
module tb_muxpga_cfg_loader;
  import muxpga_pkg::*;

  localparam int PH     = 8;
  localparam int FRAME  = CFG_W + 2 * CELL_BITS;

  logic             clk = 1'b0;
  logic             reset, sclk, sdi, sframe;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_valid, err, busy, sdo;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [CELL_BITS-1:0] cells [NCELL];
  logic [CFG_W-1:0]     exp_cfg;
  logic                 exp_valid, exp_err;

  always #5 clk = ~clk;

  muxpga_cfg_loader dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdi(sdi), .sframe(sframe),
    .cfg_out(cfg_out), .cfg_valid(cfg_valid), .err(err), .busy(busy), .sdo(sdo)
  );

  function automatic logic [CFG_W-1:0] pack_cells();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int c = 0; c < NCELL; c++) v[c*CELL_BITS +: CELL_BITS] = cells[c];
    return v;
  endfunction

  function automatic logic [CELL_BITS-1:0] cells_xor();
    logic [CELL_BITS-1:0] x;
    x = '0;
    for (int c = 0; c < NCELL; c++) x = x ^ cells[c];
    return x;
  endfunction

  // k-th bit of the committed image in readback order (cell 0 MSB first).
  function automatic logic ro_bit(input int k);
    return exp_cfg[(k / CELL_BITS) * CELL_BITS + (CELL_BITS - 1 - (k % CELL_BITS))];
  endfunction

  function automatic void random_cells();
    for (int c = 0; c < NCELL; c++) cells[c] = CELL_BITS'($urandom_range(0, 15));
  endfunction

  // mode 0: lower sframe after nbits; 1: lower sframe together with bit nbits's
  // sclk rise; 2: leave sframe high.
  task automatic drive_frame(input logic [CELL_BITS-1:0] hdr, input logic [CELL_BITS-1:0] csum,
                             input int nbits, input int mode);
    bit fb[$];
    fb = {};
    for (int b = CELL_BITS-1; b >= 0; b--) fb.push_back(hdr[b]);
    for (int c = 0; c < NCELL; c++)
      for (int b = CELL_BITS-1; b >= 0; b--) fb.push_back(cells[c][b]);
    for (int b = CELL_BITS-1; b >= 0; b--) fb.push_back(csum[b]);
    @(negedge clk); sframe = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = fb[i]; sclk = 1'b0;
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
      if (i == 0) begin
        chk_cnt++;
        if (busy !== 1'b1 || err !== 1'b0)
          $display("FAIL frame_start: busy=%b err=%b, expected busy=1 err=0", busy, err);
        else pass_cnt++;
      end
      if (i == CELL_BITS-1 && hdr != HEADER) begin
        chk_cnt++;
        if (err !== 1'b1 || busy !== 1'b0)
          $display("FAIL bad_header_flag: err=%b busy=%b, expected err=1 busy=0", err, busy);
        else pass_cnt++;
      end
      if (hdr == HEADER && i >= CELL_BITS && i < CELL_BITS + CFG_W && (i % 7 == 0)) begin
        chk_cnt++;
        if (sdo !== ro_bit((i - CELL_BITS + 1) % CFG_W))
          $display("FAIL sdo_readback bit %0d: got %b expected %b", i, sdo,
                   ro_bit((i - CELL_BITS + 1) % CFG_W));
        else pass_cnt++;
      end
    end
    if (mode == 0) begin
      sclk = 1'b0; sframe = 1'b0;
      repeat (PH + 4) @(negedge clk);
    end else if (mode == 1) begin
      sdi = fb[nbits]; sclk = 1'b0;
      repeat (PH) @(negedge clk);
      sclk = 1'b1; sframe = 1'b0;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      sclk = 1'b0;
      repeat (PH) @(negedge clk);
    end
  endtask

  task automatic check_outputs(input string name);
    chk_cnt++;
    if (cfg_out !== exp_cfg) $display("FAIL %s cfg_out: got %h expected %h", name, cfg_out, exp_cfg);
    else pass_cnt++;
    chk_cnt++;
    if (cfg_valid !== exp_valid) $display("FAIL %s cfg_valid: got %b expected %b", name, cfg_valid, exp_valid);
    else pass_cnt++;
    chk_cnt++;
    if (err !== exp_err) $display("FAIL %s err: got %b expected %b", name, err, exp_err);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL %s busy: got %b expected 0", name, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; sclk = 1'b0; sdi = 1'b0; sframe = 1'b0;
    exp_cfg = '0; exp_valid = 1'b0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    chk_cnt++;
    if (sdo !== 1'b0) $display("FAIL reset sdo: got %b expected 0", sdo);
    else pass_cnt++;
  endtask

  task automatic test_bad_header();
    random_cells();
    drive_frame(4'hB, cells_xor(), FRAME, 0);
    exp_err = 1'b1;
    check_outputs("bad_header");
  endtask

  task automatic test_valid_frame();
    for (int c = 0; c < NCELL; c++) cells[c] = CELL_BITS'(c % 16);
    drive_frame(HEADER, cells_xor(), FRAME, 0);
    exp_cfg = pack_cells(); exp_valid = 1'b1; exp_err = 1'b0;
    check_outputs("valid_frame");
    chk_cnt++;
    if (cfg_out[3:0] !== 4'h0 || cfg_out[99:96] !== 4'h8)
      $display("FAIL valid_frame cells: cell0=%h cell24=%h expected 0 and 8", cfg_out[3:0], cfg_out[99:96]);
    else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    random_cells();
    drive_frame(HEADER, cells_xor() ^ CELL_BITS'($urandom_range(1, 15)), FRAME, 0);
    exp_err = 1'b1;
    check_outputs("bad_checksum");
  endtask

  task automatic test_short_frame();
    random_cells();
    drive_frame(HEADER, cells_xor(), CELL_BITS + 50, 0);
    exp_err = 1'b1;
    check_outputs("short_frame");
    chk_cnt++;
    if (sdo !== ro_bit(0)) $display("FAIL short_frame sdo_restore: got %b expected %b", sdo, ro_bit(0));
    else pass_cnt++;
    for (int c = 0; c < NCELL; c++) cells[c] = 4'hF;
    drive_frame(HEADER, cells_xor(), FRAME, 0);
    exp_cfg = pack_cells(); exp_valid = 1'b1; exp_err = 1'b0;
    check_outputs("all_ones_frame");
  endtask

  task automatic test_coincident_drop();
    random_cells();
    drive_frame(HEADER, cells_xor(), CELL_BITS + CFG_W - 1, 1);
    exp_err = 1'b1;
    check_outputs("coincident_drop");
  endtask

  task automatic test_reset_mid_load();
    random_cells();
    drive_frame(HEADER, cells_xor(), CELL_BITS + 30, 2);
    @(negedge clk); reset = 1'b1; sframe = 1'b0; sclk = 1'b0;
    @(negedge clk);
    exp_cfg = '0; exp_valid = 1'b0; exp_err = 1'b0;
    check_outputs("reset_mid_load");
    chk_cnt++;
    if (sdo !== 1'b0) $display("FAIL reset_mid_load sdo: got %b expected 0", sdo);
    else pass_cnt++;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    random_cells();
    drive_frame(HEADER, cells_xor(), FRAME, 0);
    exp_cfg = pack_cells(); exp_valid = 1'b1;
    check_outputs("after_reset_frame");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 5; n++) begin
      logic [CELL_BITS-1:0] h, cs;
      bit corrupt;
      random_cells();
      h = HEADER;
      if ($urandom_range(0, 3) == 0) begin
        h = CELL_BITS'($urandom_range(0, 15));
        if (h == HEADER) h = 4'hB;
      end
      corrupt = ($urandom_range(0, 1) == 1);
      cs = corrupt ? (cells_xor() ^ CELL_BITS'($urandom_range(1, 15))) : cells_xor();
      drive_frame(h, cs, FRAME, 0);
      if (h == HEADER && !corrupt) begin
        exp_cfg = pack_cells(); exp_valid = 1'b1; exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
      check_outputs($sformatf("random_frame%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_bad_header();
    test_valid_frame();
    test_bad_checksum();
    test_short_frame();
    test_coincident_drop();
    test_reset_mid_load();
    test_random_frames();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
